// File: rtl/vga_frame_capture.sv
// vga_frame_capture: samples a 16 x 12 grid of one-bit cells from a VGA pixel stream.
//
// One pixel is sampled from the centre of each CELL x CELL block. A cell reads as 1
// when any colour component has its MSB set. Each frame is built in a shadow register.
// The shadow is published on the next vSync falling edge, but only if all 192 cells
// were sampled. If any cell was missed, the frame is dropped and frame_error pulses.
//
// Ports
//   clock       : pixel clock; every register updates on its rising edge
//   reset       : synchronous, active high
//   hSync       : horizontal sync, active low
//   vSync       : vertical sync, active low
//   r, g, b     : 4-bit colour components
//   data        : last complete frame; bit cy*16+cx holds cell (cx, cy)
//   frame_valid : one-cycle pulse in the cycle data takes a new frame
//   frame_error : one-cycle pulse when an incomplete frame is discarded
module vga_frame_capture #(
  parameter int unsigned H_SYNC_PULSE = 96,
  parameter int unsigned H_BACK_PORCH = 48,
  parameter int unsigned V_SYNC_PULSE = 2,
  parameter int unsigned V_BACK_PORCH = 33,
  parameter int unsigned PIXEL_DELAY  = 2,
  parameter int unsigned CELL         = 40
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         hSync,
  input  logic         vSync,
  input  logic [3:0]   r,
  input  logic [3:0]   g,
  input  logic [3:0]   b,
  output logic [191:0] data,
  output logic         frame_valid,
  output logic         frame_error
);

  localparam int unsigned GridW = 16;
  localparam int unsigned GridH = 12;
  // h_count / v_count values at the centre of cell column 0 / cell row 0
  localparam int unsigned HFirst = H_SYNC_PULSE + H_BACK_PORCH + PIXEL_DELAY + CELL / 2;
  localparam int unsigned VFirst = V_SYNC_PULSE + V_BACK_PORCH + CELL / 2;

  localparam logic [10:0] HMax    = 11'h7ff;
  localparam logic [9:0]  VMax    = 10'h3ff;
  localparam logic [7:0]  CntFull = 8'd192;

  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  state_e state_q, state_d;

  // Input stage. Only the colour MSBs affect the pixel, so only those are kept.
  logic hsync_q, hsync_prev_q, vsync_q, vsync_prev_q;
  logic r_msb_q, g_msb_q, b_msb_q;

  logic [10:0]  h_count_q, h_count_d;
  logic [9:0]   v_count_q, v_count_d;
  logic [191:0] shadow_q;
  logic [7:0]   sample_cnt_q;
  logic [191:0] data_q;
  logic         frame_valid_q, frame_valid_d;
  logic         frame_error_q, frame_error_d;

  logic       h_fall, v_fall;
  logic       hit_x, hit_y, sample_en, pixel;
  logic [3:0] cx_idx, cy_idx;
  logic       shadow_clr, publish;

  always_ff @(posedge clock) begin
    if (reset) begin
      hsync_q      <= 1'b1;
      hsync_prev_q <= 1'b1;
      vsync_q      <= 1'b1;
      vsync_prev_q <= 1'b1;
      r_msb_q      <= 1'b0;
      g_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
    end else begin
      hsync_q      <= hSync;
      hsync_prev_q <= hsync_q;
      vsync_q      <= vSync;
      vsync_prev_q <= vsync_q;
      r_msb_q      <= r[3];
      g_msb_q      <= g[3];
      b_msb_q      <= b[3];
    end
  end

  assign h_fall = hsync_prev_q & ~hsync_q;
  assign v_fall = vsync_prev_q & ~vsync_q;
  assign pixel  = r_msb_q | g_msb_q | b_msb_q;

  // Raster counters. A vSync fall wins over a coincident hSync fall, so line 0 is
  // the line that starts with the vertical sync pulse.
  always_comb begin
    h_count_d = h_count_q;
    if (h_fall) begin
      h_count_d = '0;
    end else if (h_count_q != HMax) begin
      h_count_d = h_count_q + 11'd1;
    end

    v_count_d = v_count_q;
    if (v_fall) begin
      v_count_d = '0;
    end else if (h_fall && (v_count_q != VMax)) begin
      v_count_d = v_count_q + 10'd1;
    end
  end

  // Sample-point decode: match the counters against every cell centre.
  always_comb begin
    hit_x  = 1'b0;
    cx_idx = '0;
    for (int unsigned i = 0; i < GridW; i++) begin
      if (h_count_q == 11'(HFirst + i * CELL)) begin
        hit_x  = 1'b1;
        cx_idx = 4'(i);
      end
    end
    hit_y  = 1'b0;
    cy_idx = '0;
    for (int unsigned j = 0; j < GridH; j++) begin
      if (v_count_q == 10'(VFirst + j * CELL)) begin
        hit_y  = 1'b1;
        cy_idx = 4'(j);
      end
    end
  end

  // Saturated counters mean the raster position is unknown; never sample then.
  assign sample_en = hit_x && hit_y && (h_count_q != HMax) && (v_count_q != VMax);

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if ((state_q == StIdle) && v_fall) begin
      state_d = StArmed;
    end
  end

  // FSM: outputs
  always_comb begin
    shadow_clr    = 1'b0;
    publish       = 1'b0;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The first boundary only opens a frame; what came before it is unknown.
        shadow_clr = v_fall;
      end
      StArmed: begin
        if (v_fall) begin
          if (sample_cnt_q == CntFull) begin
            publish       = 1'b1;
            frame_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_count_q     <= HMax;
      v_count_q     <= VMax;
      shadow_q      <= '0;
      sample_cnt_q  <= '0;
      data_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      if (publish) begin
        data_q <= shadow_q;
      end
      if (shadow_clr) begin
        shadow_q <= '0;
      end else if (sample_en) begin
        shadow_q[{cy_idx, cx_idx}] <= pixel;
      end
      if (v_fall) begin
        sample_cnt_q <= '0;
      end else if (sample_en && (sample_cnt_q != CntFull)) begin
        sample_cnt_q <= sample_cnt_q + 8'd1;
      end
    end
  end

  assign data        = data_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;

endmodule
